// File: rtl/ra_pq_array.sv
// Register-array priority queue.
// Entries are kept sorted by key, highest first, so the head is always
// slot 0. Enqueue, dequeue and replace (dequeue + enqueue) each finish in
// one clock. Every slot decides its next value from a single key compare
// against the incoming pair plus its neighbour's compare result. No signal
// ripples along the array.

package pq_pkg;
    parameter int KW = 8;
    parameter int VW = 8;

    typedef struct packed {
        logic [KW-1:0] key;
        logic [VW-1:0] val;
    } kv_t;
endpackage

// Two-way compare/select.
// a_gt_b is set when a outranks b. An invalid b always loses.
// On equal keys b is kept, which places new entries behind existing
// entries with the same key. Equal keys therefore leave in FIFO order.
module ra_pq_sort2
    import pq_pkg::*;
(
    input  kv_t  a,
    input  kv_t  b,
    input  logic b_valid,
    output kv_t  hi,
    output logic a_gt_b
);
    // Ordering decision and winner select.
    always_comb begin
        a_gt_b = !b_valid || (a.key > b.key);
        hi     = a_gt_b ? a : b;
    end
endmodule

module ra_pq_array
    import pq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq,
    input  kv_t           ki,
    input  logic          deq,
    output kv_t           kout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          unf
);
    // Registered storage. Valid entries are contiguous from slot 0.
    kv_t              slot [DEPTH];
    logic [DEPTH-1:0] v;

    // The "work" view is the array after an optional head removal.
    // Insertion is applied to this view, so replace needs no second cycle.
    kv_t              wk     [DEPTH];
    logic [DEPTH-1:0] wv;
    kv_t              hi     [DEPTH];
    logic [DEPTH-1:0] gt;
    kv_t              ins_kv [DEPTH];
    logic [DEPTH-1:0] ins_v;

    logic          do_enq;
    logic          do_deq;
    logic [CW-1:0] count_n;

    // Flags come only from the registered count.
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign kout  = slot[0];

    // Operation qualification. A dequeue on an empty queue is dropped.
    // An enqueue on a full queue is dropped unless a real dequeue frees
    // a slot in the same cycle.
    always_comb begin
        do_deq  = deq && !empty;
        do_enq  = enq && (!full || do_deq);
        count_n = count;
        if (do_enq && !do_deq) begin
            count_n = count + CW'(1);
        end else if (do_deq && !do_enq) begin
            count_n = count - CW'(1);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        kv_t  sh_kv;
        logic sh_v;

        // Left-shifted neighbour. Zeros enter at the tail.
        if (i < DEPTH - 1) begin : g_mid
            assign sh_kv = slot[i+1];
            assign sh_v  = v[i+1];
        end else begin : g_tail
            assign sh_kv = '0;
            assign sh_v  = 1'b0;
        end

        assign wk[i] = do_deq ? sh_kv : slot[i];
        assign wv[i] = do_deq ? sh_v  : v[i];

        ra_pq_sort2 u_cmp (
            .a       (ki),
            .b       (wk[i]),
            .b_valid (wv[i]),
            .hi      (hi[i]),
            .a_gt_b  (gt[i])
        );

        // gt is monotone along the array, because keys are non-increasing
        // and invalid slots always lose. The insertion point is therefore
        // the first slot whose gt is set. Slots after it take the
        // predecessor's entry. Slots before it keep the winner of their own
        // compare, which is their own entry.
        if (i == 0) begin : g_head
            assign ins_kv[i] = hi[i];
            assign ins_v[i]  = 1'b1;
        end else begin : g_body
            assign ins_kv[i] = gt[i-1] ? wk[i-1] : hi[i];
            assign ins_v[i]  = gt[i-1] ? wv[i-1] : (gt[i] | wv[i]);
        end
    end

    // State update: array, valid bits, count and the error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot[i] <= '0;
            end
            v     <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (do_enq || do_deq) begin
                for (int i = 0; i < DEPTH; i++) begin
                    slot[i] <= do_enq ? ins_kv[i] : wk[i];
                end
                v <= do_enq ? ins_v : wv;
            end
            count <= count_n;
            ovf   <= enq && !deq && full;
            unf   <= deq && empty;
        end
    end
endmodule

// File: tb/tb_ra_pq_array.sv
// Directed bench for ra_pq_array.
// A table of single-cycle vectors holds the expected outputs after each
// edge. Hand-written sequences cover fill/overflow, replace on a full
// array and an asynchronous reset in the middle of a stream.
module tb_ra_pq_array;
    import pq_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enq = 1'b0;
    logic          deq = 1'b0;
    kv_t           ki  = '0;
    kv_t           kout;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          ovf;
    logic          unf;

    int tests = 0;
    int fails = 0;

    ra_pq_array #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .enq   (enq),
        .ki    (ki),
        .deq   (deq),
        .kout  (kout),
        .empty (empty),
        .full  (full),
        .count (count),
        .ovf   (ovf),
        .unf   (unf)
    );

    // Clock.
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       enq;
        logic       deq;
        logic [7:0] key;
        logic [7:0] val;
        int         chk_key;   // 1: compare head key
        logic [7:0] ekey;
        int         chk_val;   // 1: compare head value
        logic [7:0] eval;
        logic [CW-1:0] ecnt;
        logic       eempty;
        logic       efull;
        logic       eovf;
        logic       eunf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic e, logic d,
                                logic [7:0] k, logic [7:0] v,
                                int ck, logic [7:0] ek,
                                int cv, logic [7:0] ev,
                                int ecnt, logic eovf, logic eunf);
        vec_t r;
        r.name = name; r.enq = e; r.deq = d; r.key = k; r.val = v;
        r.chk_key = ck; r.ekey = ek; r.chk_val = cv; r.eval = ev;
        r.ecnt = CW'(ecnt);
        r.eempty = (ecnt == 0);
        r.efull = (ecnt == DEPTH);
        r.eovf = eovf; r.eunf = eunf;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one request for exactly one rising edge, then settle.
    task automatic step(logic e, logic d, logic [7:0] k, logic [7:0] v);
        @(negedge clk);
        enq = e; deq = d; ki.key = k; ki.val = v;
        @(posedge clk);
        #1;
        enq = 1'b0; deq = 1'b0;
    endtask

    task automatic check_flags(string tag, int ecnt, logic eovf, logic eunf);
        check({tag, ".count"}, 32'(count), 32'(ecnt));
        check({tag, ".empty"}, 32'(empty), 32'(ecnt == 0));
        check({tag, ".full"},  32'(full),  32'(ecnt == DEPTH));
        check({tag, ".ovf"},   32'(ovf),   32'(eovf));
        check({tag, ".unf"},   32'(unf),   32'(eunf));
    endtask

    logic [7:0] exp_q[$];

    initial begin
        // Basic insert order, then drain.
        vecs.push_back(mk("ins5",   1, 0, 5, 0, 1, 5, 0, 0, 1, 0, 0));
        vecs.push_back(mk("ins9",   1, 0, 9, 0, 1, 9, 0, 0, 2, 0, 0));
        vecs.push_back(mk("ins1",   1, 0, 1, 0, 1, 9, 0, 0, 3, 0, 0));
        vecs.push_back(mk("ins7",   1, 0, 7, 0, 1, 9, 0, 0, 4, 0, 0));
        vecs.push_back(mk("deq1",   0, 1, 0, 0, 1, 7, 0, 0, 3, 0, 0));
        vecs.push_back(mk("deq2",   0, 1, 0, 0, 1, 5, 0, 0, 2, 0, 0));
        vecs.push_back(mk("deq3",   0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk("deq4",   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Empty corner cases.
        vecs.push_back(mk("deq_e",  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rep_e",  1, 1, 3, 0, 1, 3, 0, 0, 1, 0, 1));
        vecs.push_back(mk("deq_r",  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Equal keys leave in FIFO order.
        vecs.push_back(mk("tieA",   1, 0, 4, 8'hA, 1, 4, 1, 8'hA, 1, 0, 0));
        vecs.push_back(mk("tieB",   1, 0, 4, 8'hB, 1, 4, 1, 8'hA, 2, 0, 0));
        vecs.push_back(mk("tieC",   1, 0, 4, 8'hC, 1, 4, 1, 8'hA, 3, 0, 0));
        vecs.push_back(mk("tdq1",   0, 1, 0, 0,    1, 4, 1, 8'hB, 2, 0, 0));
        vecs.push_back(mk("tdq2",   0, 1, 0, 0,    1, 4, 1, 8'hC, 1, 0, 0));
        vecs.push_back(mk("tdq3",   0, 1, 0, 0,    0, 0, 0, 0,    0, 0, 0));
        // Replace on a partly filled array, including a tie on replace.
        vecs.push_back(mk("p8",     1, 0, 8, 1, 1, 8, 0, 0, 1, 0, 0));
        vecs.push_back(mk("p3",     1, 0, 3, 2, 1, 8, 0, 0, 2, 0, 0));
        vecs.push_back(mk("rep5",   1, 1, 5, 3, 1, 5, 1, 3, 2, 0, 0));
        vecs.push_back(mk("rep3",   1, 1, 3, 4, 1, 3, 1, 2, 2, 0, 0));
        vecs.push_back(mk("pdq1",   0, 1, 0, 0, 1, 3, 1, 4, 1, 0, 0));
        vecs.push_back(mk("pdq2",   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset: held over two edges, released on a falling edge.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_flags("reset", 0, 1'b0, 1'b0);
        check("reset.kout", 32'(kout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors.
        foreach (vecs[n]) begin
            step(vecs[n].enq, vecs[n].deq, vecs[n].key, vecs[n].val);
            check({vecs[n].name, ".count"}, 32'(count), 32'(vecs[n].ecnt));
            check({vecs[n].name, ".empty"}, 32'(empty), 32'(vecs[n].eempty));
            check({vecs[n].name, ".full"},  32'(full),  32'(vecs[n].efull));
            check({vecs[n].name, ".ovf"},   32'(ovf),   32'(vecs[n].eovf));
            check({vecs[n].name, ".unf"},   32'(unf),   32'(vecs[n].eunf));
            if (vecs[n].chk_key != 0)
                check({vecs[n].name, ".key"}, 32'(kout.key), 32'(vecs[n].ekey));
            if (vecs[n].chk_val != 0)
                check({vecs[n].name, ".val"}, 32'(kout.val), 32'(vecs[n].eval));
        end

        // Fill with 1..16. The newest key is always the maximum.
        for (int k = 1; k <= DEPTH; k++) begin
            step(1'b1, 1'b0, 8'(k), 8'(k));
            check($sformatf("fill%0d.key", k), 32'(kout.key), 32'(k));
            check($sformatf("fill%0d.count", k), 32'(count), 32'(k));
        end
        check("fill.full", 32'(full), 32'd1);

        // Overflow: dropped, one-cycle pulse.
        step(1'b1, 1'b0, 8'd20, 8'd0);
        check_flags("ovf", DEPTH, 1'b1, 1'b0);
        check("ovf.key", 32'(kout.key), 32'd16);
        step(1'b0, 1'b0, 8'd0, 8'd0);
        check_flags("ovf_end", DEPTH, 1'b0, 1'b0);

        // Replace while full: 16 leaves, 10 joins behind the existing 10.
        step(1'b1, 1'b1, 8'd10, 8'hEE);
        check_flags("rep_full", DEPTH, 1'b0, 1'b0);
        check("rep_full.key", 32'(kout.key), 32'd15);

        for (int k = 15; k >= 10; k--) exp_q.push_back(8'(k));
        for (int k = 10; k >= 2; k--) exp_q.push_back(8'(k));
        for (int n = 0; n < DEPTH; n++) begin
            if (n < exp_q.size())
                check($sformatf("drain%0d.key", n), 32'(kout.key), 32'(exp_q[n]));
            step(1'b0, 1'b1, 8'd0, 8'd0);
            check($sformatf("drain%0d.count", n), 32'(count), 32'(DEPTH - 1 - n));
        end
        // The old key-10 entry (val 10) leaves before the replacement 10.
        check("drain.empty", 32'(empty), 32'd1);

        // Reset in the middle of a stream acts without a clock edge.
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 8'(k + 30), 8'd0);
        check("pre_rst.count", 32'(count), 32'd6);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.empty", 32'(empty), 32'd1);
        check("async_rst.count", 32'(count), 32'd0);
        check("async_rst.kout", 32'(kout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'd2, 8'd0);
        check("post_rst.key", 32'(kout.key), 32'd2);
        check_flags("post_rst", 1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ra_pq_array.md
# ra_pq_array

Register-array priority queue storing up to DEPTH key-value pairs (`kv_t` from `pq_pkg`) in a sorted register file. Slot 0 always holds the highest-key entry, so the head is available with no search. Enqueue, dequeue and combined replace each complete in one clock. Per-slot compare logic uses the same greater/less ordering as `ra_pq_sort2`, which sits inside this block's comparison network. The block is the storage stage that sorted pairs are consumed into and served from.

## Interface
- DEPTH, 16: number of entries; must be ≥ 2.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- enq  in  1  enqueue request for `ki` this cycle.
- ki  in  kv_t  key-value pair to insert.
- deq  in  1  dequeue request; removes the current head.
- kout  out  kv_t  current head, which is slot 0. Meaningful only when `empty` = 0.
- empty  out  1  queue holds 0 entries.
- full  out  1  queue holds DEPTH entries.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- ovf  out  1  one-cycle pulse: an enqueue was dropped.
- unf  out  1  one-cycle pulse: a dequeue was ignored.

## Operation
- Storage:
  - `slot[0..DEPTH-1]` of `kv_t`, plus valid bits `v[0..DEPTH-1]`.
  - Invariant: valid entries are contiguous from slot 0.
  - Invariant: key is non-increasing with index (`slot[i].key >= slot[i+1].key`).
  - Invalid slots compare as lower than any key.
- Tie rule: on insert, the new entry is placed after all existing entries with an equal key. Equal keys therefore leave in FIFO order.
- Operation select per cycle (the state is the occupancy count):
  - IDLE (`enq`=0, `deq`=0): no change.
  - ENQ (`enq`=1, `deq`=0, not full):
    - Slot i takes `ki` when `ki.key > slot[i].key` (or `v[i]`=0), and i=0 or (`v[i-1]`=1 and `slot[i-1].key >= ki.key`).
    - Slots below the insertion point take `slot[i-1]`.
    - Slots above the insertion point hold.
    - `count`+1.
  - ENQ while full, `deq`=0: array unchanged, `ovf`=1.
  - DEQ (`deq`=1, `enq`=0, not empty):
    - `slot[i] <= slot[i+1]`, `v[i] <= v[i+1]`.
    - `v[DEPTH-1] <= 0`.
    - `count`-1.
  - DEQ while empty, `enq`=0: array unchanged, `unf`=1.
  - REPLACE (`enq`=1, `deq`=1, not empty):
    - Conceptually shift the array left (head removed), then apply the ENQ rule to the shifted array.
    - Both steps happen in one cycle; `count` is unchanged.
    - Legal when full; no `ovf`.
  - `enq`=1, `deq`=1, empty: the dequeue is ignored and `unf`=1; the enqueue proceeds and `count` becomes 1.
- Flags:
  - `empty` = (`count`==0).
  - `full` = (`count`==DEPTH).
  - Both are derived from registered `count`, with no combinational path from inputs.
- `ki` is ignored when `enq`=0. Contents of invalid slots are don't-care but must never reach `kout` while `empty`=0.

## Timing
- Reset (asynchronous assert, released synchronously by the system):
  - all `v` = 0, `count` = 0, `empty` = 1, `full` = 0, `ovf` = 0, `unf` = 0.
  - `kout` = all zeros (slot contents are cleared on reset).
- Reset asserted mid-operation discards all entries immediately. The first edge after release samples requests normally.
- Latency:
  - An insert or removal on edge N is visible on `kout`/`count`/`flags` after edge N.
  - Back-to-back operations every cycle are supported; there is no busy state.
- Outputs are registered: `kout` is `slot[0]`, and `ovf`/`unf` are registered pulses that are high for exactly the cycle after the offending request.
- The critical path is one key comparison per slot plus a mux. There is no serial chain across slots.

## Test plan
- Reset then insert: insert keys 5, 9, 1, 7 on consecutive cycles.
  - `kout.key` sequence: 5, 9, 9, 9.
  - `count` reaches 4.
  - Four dequeues yield 9, 7, 5, 1, then `empty`=1.
- Tie FIFO: enqueue (key 4, val A), (4, B), (4, C), then dequeue ×3 → values A, B, C in that order.
- Full/overflow (DEPTH=16): enqueue keys 1..16, so `full`=1. Enqueue key 20 → `ovf` pulses, `kout.key` stays 16, `count` stays 16.
- Replace while full: with keys 1..16 held, `enq`=`deq`=1 with key 10 → `kout.key`=15 next cycle, `count`=16. Dequeuing the rest yields 15, 14, 13, 12, 11, 10, 10, 9, …, 2.
- Empty edge cases:
  - `deq` on empty → `unf` pulse, state unchanged.
  - `enq`+`deq` on empty with key 3 → `unf` pulse, `count`=1, `kout.key`=3.
- Reset mid-stream: load 6 entries and assert `rst` between edges → `empty`=1 and `count`=0 immediately, without waiting for a clock. After release, enqueue key 2 → `kout.key`=2.
